// File: rtl/factorial_pkg.sv
// factorial_pkg: shared definitions for the factorial requester slice.
//   IN_DATA_WD_DFLT / OUT_DATA_WD_DFLT : default operand / result widths
//   req_state_t                        : requester FSM state encoding
//   fact_expected(n, wd)               : n! truncated to wd bits (wd <= 64),
//                                        returned zero-extended to 64 bits
package factorial_pkg;

  localparam int unsigned IN_DATA_WD_DFLT  = 3;
  localparam int unsigned OUT_DATA_WD_DFLT = 16;

  // Largest operand the reference function will expand.
  localparam int unsigned FACT_MAX_N = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } req_state_t;

  // Constant loop bound so the function also elaborates cleanly when called
  // with a non-constant operand; in the RTL it is only used to build a LUT.
  function automatic logic [63:0] fact_expected(input int unsigned n,
                                                input int unsigned wd);
    logic [63:0] acc;
    acc = 64'd1;
    for (int unsigned i = 2; i <= FACT_MAX_N; i++) begin
      if (i <= n) acc = acc * 64'(i);
    end
    if (wd < 64) acc = acc & ((64'd1 << wd) - 64'd1);
    return acc;
  endfunction

endpackage

// File: rtl/factorial_req_fifo.sv
// factorial_req_fifo: synchronous request FIFO with first-word-fall-through
// head. Full/empty are registered from the next occupancy count.
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write strobe / data (ignored while full)
//   pop             : consume head (ignored while empty)
//   head            : oldest entry, valid whenever empty = 0
//   full, empty     : occupancy flags
//   count           : number of stored entries
module factorial_req_fifo
  import factorial_pkg::*;
#(
  parameter int unsigned WIDTH = IN_DATA_WD_DFLT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/factorial_requester.sv
// factorial_requester: initiator side of the factorial engine handshake.
// Queues operand requests, issues them one at a time, checks each result
// against n! (mod 2^OUT_DATA_WD) and reports a response plus counters.
//   clk, resetn                    : clock, synchronous reset (active high)
//   req_data/req_valid/req_ready   : upstream request push interface
//   fac_in_data/fac_in_valid       : issue to engine (one-cycle strobe)
//   fac_out_data/fac_out_valid     : engine result strobe
//   fac_out_busy                   : engine busy, holds off issue
//   rsp_operand/rsp_data/rsp_valid : per-request response (one-cycle strobe)
//   rsp_ok/rsp_timeout             : result matched / request timed out
//   done_count/err_count           : saturating response / error counters
//   idle                           : FSM idle and FIFO empty
module factorial_requester
  import factorial_pkg::*;
#(
  parameter int unsigned IN_DATA_WD     = IN_DATA_WD_DFLT,
  parameter int unsigned OUT_DATA_WD    = OUT_DATA_WD_DFLT,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [IN_DATA_WD-1:0]  req_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [IN_DATA_WD-1:0]  fac_in_data,
  output logic                   fac_in_valid,
  input  logic [OUT_DATA_WD-1:0] fac_out_data,
  input  logic                   fac_out_valid,
  input  logic                   fac_out_busy,
  output logic [IN_DATA_WD-1:0]  rsp_operand,
  output logic [OUT_DATA_WD-1:0] rsp_data,
  output logic                   rsp_valid,
  output logic                   rsp_ok,
  output logic                   rsp_timeout,
  output logic [15:0]            done_count,
  output logic [15:0]            err_count,
  output logic                   idle
);

  localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int unsigned NUM_OPS  = 2 ** IN_DATA_WD;

  // Request FIFO
  logic                       fifo_push;
  logic                       fifo_pop;
  logic [IN_DATA_WD-1:0]      fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign fifo_push = req_valid && req_ready;

  factorial_req_fifo #(
    .WIDTH (IN_DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (resetn),
    .push    (fifo_push),
    .wr_data (req_data),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Expected results folded to constants at elaboration.
  logic [63:0] exp_lut [NUM_OPS];
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_exp_lut
    assign exp_lut[k] = fact_expected(k, OUT_DATA_WD);
  end

  // State and registered outputs
  req_state_t             state_q, state_d;
  logic                   fiv_q, fiv_d;
  logic [IN_DATA_WD-1:0]  fin_data_q, fin_data_d;
  logic [IN_DATA_WD-1:0]  op_q, op_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_ok_q, rsp_ok_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [OUT_DATA_WD-1:0] rsp_data_q, rsp_data_d;
  logic [IN_DATA_WD-1:0]  rsp_operand_q, rsp_operand_d;
  logic [15:0]            done_q, done_d;
  logic [15:0]            err_q, err_d;

  always_comb begin
    state_d       = state_q;
    fiv_d         = 1'b0;
    fin_data_d    = fin_data_q;
    op_d          = op_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = 1'b0;
    rsp_ok_d      = rsp_ok_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;
    rsp_operand_d = rsp_operand_q;
    done_d        = done_q;
    err_d         = err_q;
    fifo_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !fac_out_busy) begin
          state_d    = ISSUE;
          fiv_d      = 1'b1;
          fin_data_d = fifo_head;
          tmo_d      = '0;
        end
      end
      ISSUE: begin
        // Counter runs from the issue cycle, so the timeout response lands
        // TIMEOUT_CYCLES cycles after fac_in_valid.
        fifo_pop = 1'b1;
        op_d     = fifo_head;
        tmo_d    = tmo_q + TW'(1);
        state_d  = WAIT;
      end
      WAIT: begin
        if (fac_out_valid) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = fac_out_data;
          rsp_ok_d      = (64'(fac_out_data) == exp_lut[op_q]);
          rsp_timeout_d = 1'b0;
          rsp_operand_d = op_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_operand_d = op_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_valid_d) begin
      if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
      if (!rsp_ok_d && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= IDLE;
      fiv_q         <= 1'b0;
      fin_data_q    <= '0;
      op_q          <= '0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_operand_q <= '0;
      done_q        <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      fiv_q         <= fiv_d;
      fin_data_q    <= fin_data_d;
      op_q          <= op_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      rsp_operand_q <= rsp_operand_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign req_ready    = !fifo_full;
  assign fac_in_valid = fiv_q;
  assign fac_in_data  = fin_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_ok       = rsp_ok_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_operand  = rsp_operand_q;
  assign done_count   = done_q;
  assign err_count    = err_q;
  assign idle         = (state_q == IDLE) && (fifo_count == '0);

endmodule

// File: tb/tb_factorial_requester.sv
// tb_factorial_requester: directed self-checking bench for factorial_requester.
// A behavioural engine answers issues after a programmable delay; a monitor
// logs every issue and response with its cycle number for later checks.
`timescale 1ns/1ps
module tb_factorial_requester;
  import factorial_pkg::*;

  localparam int unsigned IW = 3;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [IW-1:0] req_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] fac_in_data;
  logic          fac_in_valid;
  logic [OW-1:0] fac_out_data = '0;
  logic          fac_out_valid = 1'b0;
  logic          fac_out_busy = 1'b0;
  logic [IW-1:0] rsp_operand;
  logic [OW-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_ok;
  logic          rsp_timeout;
  logic [15:0]   done_count;
  logic [15:0]   err_count;
  logic          idle;

  factorial_requester #(
    .IN_DATA_WD     (IW),
    .OUT_DATA_WD    (OW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .fac_in_data   (fac_in_data),
    .fac_in_valid  (fac_in_valid),
    .fac_out_data  (fac_out_data),
    .fac_out_valid (fac_out_valid),
    .fac_out_busy  (fac_out_busy),
    .rsp_operand   (rsp_operand),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ok        (rsp_ok),
    .rsp_timeout   (rsp_timeout),
    .done_count    (done_count),
    .err_count     (err_count),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Monitor log
  int unsigned   rsp_n = 0;
  int unsigned   iss_n = 0;
  logic [IW-1:0] rsp_op  [64];
  logic [OW-1:0] rsp_dat [64];
  logic          rsp_okv [64];
  logic          rsp_to  [64];
  int unsigned   rsp_cy  [64];
  logic [IW-1:0] iss_dat [64];
  int unsigned   iss_cy  [64];

  always @(negedge clk) begin
    if (rsp_valid && rsp_n < 64) begin
      rsp_op[rsp_n]  = rsp_operand;
      rsp_dat[rsp_n] = rsp_data;
      rsp_okv[rsp_n] = rsp_ok;
      rsp_to[rsp_n]  = rsp_timeout;
      rsp_cy[rsp_n]  = cyc;
      rsp_n++;
    end
    if (fac_in_valid && iss_n < 64) begin
      iss_dat[iss_n] = fac_in_data;
      iss_cy[iss_n]  = cyc;
      iss_n++;
    end
  end

  // Engine model: mode 0 = correct n!, 1 = fixed eng_val, 2 = never answers.
  int unsigned   eng_mode = 0;
  int unsigned   eng_delay = 3;
  logic [OW-1:0] eng_val = '0;
  int unsigned   pulse_req = 0;
  int unsigned   pulse_seen = 0;
  logic [OW-1:0] pulse_val = '0;
  logic [IW-1:0] eng_op;
  logic [63:0]   eng_full;

  always begin
    @(negedge clk);
    if (pulse_req != pulse_seen) begin
      pulse_seen    = pulse_req;
      fac_out_data  = pulse_val;
      fac_out_valid = 1'b1;
      @(negedge clk);
      fac_out_valid = 1'b0;
    end else if (fac_in_valid && eng_mode != 2) begin
      eng_op   = fac_in_data;
      eng_full = fact_expected(32'(eng_op), OW);
      repeat (eng_delay) @(negedge clk);
      fac_out_data  = (eng_mode == 1) ? eng_val : eng_full[OW-1:0];
      fac_out_valid = 1'b1;
      @(negedge clk);
      fac_out_valid = 1'b0;
    end
  end

  task automatic do_reset();
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle in which the push was presented
  // with req_ready high (accepted at the following rising edge).
  task automatic push(input logic [IW-1:0] d, output int unsigned acc_cyc);
    int unsigned n = 0;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    check("push_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_issue(input int unsigned target);
    int unsigned n = 0;
    while (iss_n < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", iss_n >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [IW-1:0] t3_ops [5] = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd2};
  logic [OW-1:0] t3_exp [5] = '{16'd1, 16'd1, 16'd720, 16'd5040, 16'd2};

  initial begin
    int unsigned rb, ib, pc, pc2;

    // Reset state
    do_reset();
    check("rst_req_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fac_in_valid", fac_in_valid, 0);
    check("rst_rsp_ok", rsp_ok, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_done", done_count, 0);
    check("rst_err", err_count, 0);

    // T1: request 5, engine answers 120 three cycles after issue
    eng_mode = 0; eng_delay = 3;
    rb = rsp_n; ib = iss_n;
    push(3'd5, pc);
    repeat (12) @(negedge clk);
    check("t1_issues", iss_n - ib, 1);
    check("t1_issue_data", iss_dat[ib], 5);
    check("t1_issue_lat", iss_cy[ib] - pc, 2);
    check("t1_rsp_n", rsp_n - rb, 1);
    check("t1_rsp_op", rsp_op[rb], 5);
    check("t1_rsp_data", rsp_dat[rb], 120);
    check("t1_rsp_ok", rsp_okv[rb], 1);
    check("t1_rsp_to", rsp_to[rb], 0);
    check("t1_rsp_lat", rsp_cy[rb] - iss_cy[ib], 4);
    check("t1_done", done_count, 1);
    check("t1_err", err_count, 0);
    check("t1_fin_hold", fac_in_data, 5);
    check("t1_idle", idle, 1);

    // T2: request 3, engine returns wrong value 7
    do_reset();
    eng_mode = 1; eng_val = 16'd7; eng_delay = 3;
    rb = rsp_n; ib = iss_n;
    push(3'd3, pc);
    repeat (12) @(negedge clk);
    check("t2_rsp_n", rsp_n - rb, 1);
    check("t2_rsp_op", rsp_op[rb], 3);
    check("t2_rsp_data", rsp_dat[rb], 7);
    check("t2_rsp_ok", rsp_okv[rb], 0);
    check("t2_rsp_to", rsp_to[rb], 0);
    check("t2_done", done_count, 1);
    check("t2_err", err_count, 1);

    // T3: engine busy while filling the FIFO, then release
    do_reset();
    eng_mode = 0; eng_delay = 2;
    fac_out_busy = 1'b1;
    rb = rsp_n; ib = iss_n;
    for (int i = 0; i < 4; i++) push(t3_ops[i], pc);
    repeat (5) @(negedge clk);
    check("t3_ready_full", req_ready, 0);
    check("t3_no_issue_busy", iss_n - ib, 0);
    check("t3_not_idle", idle, 0);
    fac_out_busy = 1'b0;
    push(t3_ops[4], pc);
    repeat (60) @(negedge clk);
    check("t3_rsp_n", rsp_n - rb, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_rsp_op%0d", i), rsp_op[rb+i], t3_ops[i]);
      check($sformatf("t3_rsp_data%0d", i), rsp_dat[rb+i], t3_exp[i]);
      check($sformatf("t3_rsp_ok%0d", i), rsp_okv[rb+i], 1);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_b2b%0d", i), iss_cy[ib+i+1] > rsp_cy[rb+i], 1);
    check("t3_done", done_count, 5);
    check("t3_err", err_count, 0);

    // T4: request 4 never answered, request 5 queued behind it
    do_reset();
    eng_mode = 2; eng_delay = 3;
    rb = rsp_n; ib = iss_n;
    push(3'd4, pc);
    push(3'd5, pc2);
    wait_issue(ib + 1);
    repeat (3) @(negedge clk);
    eng_mode = 0;
    repeat (80) @(negedge clk);
    check("t4_rsp_n", rsp_n - rb, 2);
    check("t4_to_op", rsp_op[rb], 4);
    check("t4_to_data", rsp_dat[rb], 0);
    check("t4_to_ok", rsp_okv[rb], 0);
    check("t4_to_flag", rsp_to[rb], 1);
    check("t4_to_lat", rsp_cy[rb] - iss_cy[ib], 64);
    check("t4_next_issue_data", iss_dat[ib+1], 5);
    check("t4_next_after_to", iss_cy[ib+1] > rsp_cy[rb], 1);
    check("t4_next_op", rsp_op[rb+1], 5);
    check("t4_next_data", rsp_dat[rb+1], 120);
    check("t4_next_ok", rsp_okv[rb+1], 1);
    check("t4_done", done_count, 2);
    check("t4_err", err_count, 1);

    // T5: spurious fac_out_valid while idle
    rb = rsp_n;
    pulse_val = 16'd99;
    pulse_req++;
    repeat (6) @(negedge clk);
    check("t5_no_rsp", rsp_n - rb, 0);
    check("t5_done", done_count, 2);
    check("t5_err", err_count, 1);
    check("t5_idle", idle, 1);

    // T6: reset during WAIT, engine answers afterwards
    do_reset();
    eng_mode = 0; eng_delay = 10;
    rb = rsp_n; ib = iss_n;
    push(3'd6, pc);
    wait_issue(ib + 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    check("t6_fiv_after_rst", fac_in_valid, 0);
    repeat (20) @(negedge clk);
    check("t6_no_rsp", rsp_n - rb, 0);
    check("t6_one_issue", iss_n - ib, 1);
    check("t6_done", done_count, 0);
    check("t6_err", err_count, 0);
    check("t6_idle", idle, 1);
    check("t6_req_ready", req_ready, 1);
    check("t6_rsp_valid", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
